// File: rtl/goal_detector.sv
// Goal detector: watches ball_x once per frame, emits registered score pulses,
// sequences pause / re-serve and stops play when a player reaches WIN_SCORE.
module goal_detector #(
    parameter int H_ACTIVE     = 640,
    parameter int BALL_SIZE    = 8,
    parameter int LEFT_LIMIT   = 0,
    parameter int RIGHT_LIMIT  = H_ACTIVE - BALL_SIZE,
    parameter int PAUSE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] ball_x,
    output logic       score1,
    output logic       score2,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       play_en,
    output logic       game_over,
    output logic       winner
);

    // state  | meaning
    // IDLE   | waiting for start
    // SERVE  | one clk, ball engine re-centres the ball
    // PLAY   | ball in motion, edges checked on frame_tick
    // SCORED | one clk, score pulse out, win check
    // PAUSE  | holding PAUSE_FRAMES frames before re-serve
    // OVER   | terminal until reset
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        PAUSE  = 3'd4,
        OVER   = 3'd5
    } state_t;

    localparam int CW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
    localparam logic [9:0]    LEFT_L     = 10'(LEFT_LIMIT);
    localparam logic [9:0]    RIGHT_L    = 10'(RIGHT_LIMIT);

    state_t        state, state_nxt;
    logic [3:0]    p1_pts, p1_nxt;
    logic [3:0]    p2_pts, p2_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          serve_dir_nxt, winner_nxt;
    logic          score1_nxt, score2_nxt;
    logic          hit_left, hit_right;

    assign hit_left  = (ball_x <= LEFT_L);
    assign hit_right = (ball_x >= RIGHT_L);

    always_comb begin
        state_nxt     = state;
        p1_nxt        = p1_pts;
        p2_nxt        = p2_pts;
        cnt_nxt       = cnt;
        serve_dir_nxt = serve_dir;
        winner_nxt    = winner;
        score1_nxt    = 1'b0;
        score2_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SERVE;
            end
            SERVE: begin
                state_nxt = PLAY;
            end
            PLAY: begin
                // left exit wins a tie so degenerate limits still give one pulse
                if (frame_tick && hit_left) begin
                    state_nxt     = SCORED;
                    score2_nxt    = 1'b1;
                    serve_dir_nxt = 1'b0;
                    p2_nxt        = (p2_pts == WIN) ? p2_pts : p2_pts + 4'd1;
                end else if (frame_tick && hit_right) begin
                    state_nxt     = SCORED;
                    score1_nxt    = 1'b1;
                    serve_dir_nxt = 1'b1;
                    p1_nxt        = (p1_pts == WIN) ? p1_pts : p1_pts + 4'd1;
                end
            end
            SCORED: begin
                if (p1_pts == WIN || p2_pts == WIN) begin
                    state_nxt  = OVER;
                    winner_nxt = (p2_pts == WIN);
                end else begin
                    state_nxt = PAUSE;
                    cnt_nxt   = '0;
                end
            end
            PAUSE: begin
                if (frame_tick) begin
                    if (cnt == PAUSE_LAST) state_nxt = SERVE;
                    else                   cnt_nxt   = cnt + 1'b1;
                end
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // every output is a flop loaded from the next-state decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            p1_pts     <= '0;
            p2_pts     <= '0;
            cnt        <= '0;
            serve_dir  <= 1'b0;
            winner     <= 1'b0;
            score1     <= 1'b0;
            score2     <= 1'b0;
            ball_reset <= 1'b0;
            play_en    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            p1_pts     <= p1_nxt;
            p2_pts     <= p2_nxt;
            cnt        <= cnt_nxt;
            serve_dir  <= serve_dir_nxt;
            winner     <= winner_nxt;
            score1     <= score1_nxt;
            score2     <= score2_nxt;
            ball_reset <= (state_nxt == SERVE);
            play_en    <= (state_nxt == PLAY);
            game_over  <= (state_nxt == OVER);
        end
    end

endmodule

// File: tb/tb_goal_detector.sv
// Directed bench for goal_detector; pulse outputs are checked against a queue
// of expected events filled as each stimulus step is driven.
module tb_goal_detector;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [9:0] ball_x;
    logic       score1, score2, ball_reset, serve_dir, play_en, game_over, winner;

    localparam logic [2:0] EV_S1 = 3'b001;
    localparam logic [2:0] EV_S2 = 3'b010;
    localparam logic [2:0] EV_BR = 3'b100;

    int passed = 0;
    int total  = 0;
    int s1_cnt = 0;
    int s2_cnt = 0;
    int br_cnt = 0;
    int b0, s0;
    logic [2:0] sb[$];
    logic [2:0] mon_obs, mon_exp;

    goal_detector dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .ball_x     (ball_x),
        .score1     (score1),
        .score2     (score2),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .play_en    (play_en),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // pulse monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        mon_obs = {ball_reset, score2, score1};
        if (score1)     s1_cnt++;
        if (score2)     s2_cnt++;
        if (ball_reset) br_cnt++;
        if (mon_obs != 3'b000) begin
            if (sb.size() == 0) begin
                total++;
                $error("FAIL unexpected_pulse observed=%b expected=none", mon_obs);
            end else begin
                mon_exp = sb.pop_front();
                chk("pulse", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; ball_x = 10'd320;
        repeat (3) @(negedge clk);
        chk("rst_score1", 32'(score1), 0);
        chk("rst_score2", 32'(score2), 0);
        chk("rst_ball_reset", 32'(ball_reset), 0);
        chk("rst_play_en", 32'(play_en), 0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_serve_dir", 32'(serve_dir), 0);
        chk("rst_winner", 32'(winner), 0);

        // start and rally in the middle
        reset = 1'b0;
        @(negedge clk);
        sb.push_back(EV_BR);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("serve_play_en", 32'(play_en), 1);
        chk("serve_sb_empty", 32'(sb.size()), 0);
        frames(10);
        chk("rally_play_en", 32'(play_en), 1);
        chk("rally_no_score", 32'(s1_cnt + s2_cnt), 0);

        // left exit: player 2 point, full pause, re-serve
        ball_x = 10'd0;
        sb.push_back(EV_S2);
        sb.push_back(EV_BR);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("left_score1_low", 32'(score1), 0);
        chk("left_serve_dir", 32'(serve_dir), 0);
        chk("left_play_en", 32'(play_en), 0);
        ball_x = 10'd320;
        repeat (3) @(negedge clk);
        frames(59);
        chk("pause59_play_en", 32'(play_en), 0);
        chk("pause59_pending", 32'(sb.size()), 1);
        frames(1);
        chk("pause60_play_en", 32'(play_en), 1);
        chk("pause60_sb_empty", 32'(sb.size()), 0);

        // right exit held: one pulse, one re-serve (ball engine recentres on serve)
        ball_x = 10'd632;
        sb.push_back(EV_S1);
        sb.push_back(EV_BR);
        b0 = br_cnt;
        s0 = s1_cnt;
        for (int i = 0; i < 200; i++) begin
            frames(1);
            if (i == 0) chk("right_serve_dir", 32'(serve_dir), 1);
            if (br_cnt != b0) ball_x = 10'd320;
        end
        chk("hold_one_score1", 32'(s1_cnt - s0), 1);
        chk("hold_one_serve", 32'(br_cnt - b0), 1);
        chk("hold_sb_empty", 32'(sb.size()), 0);

        // reset 30 frames into a pause
        ball_x = 10'd632;
        sb.push_back(EV_S1);
        sb.push_back(EV_BR);
        frames(1);
        ball_x = 10'd320;
        frames(30);
        chk("midpause_play_en", 32'(play_en), 0);
        reset = 1'b1;
        #1;
        chk("arst_serve_dir", 32'(serve_dir), 0);
        chk("arst_ball_reset", 32'(ball_reset), 0);
        chk("arst_game_over", 32'(game_over), 0);
        chk("arst_state_idle", 32'(dut.state), 0);
        chk("arst_p1_pts", 32'(dut.p1_pts), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back(EV_BR);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("fresh_play_en", 32'(play_en), 1);
        chk("fresh_p1_pts", 32'(dut.p1_pts), 0);

        // edge crossed without frame_tick, then tick also held in SCORED clk
        ball_x = 10'd0;
        sb.push_back(EV_S2);
        sb.push_back(EV_BR);
        s0 = s2_cnt;
        repeat (100) @(negedge clk);
        chk("notick_no_score2", 32'(s2_cnt - s0), 0);
        frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        ball_x = 10'd320;
        repeat (2) @(negedge clk);
        chk("tick_score2", 32'(s2_cnt - s0), 1);
        frames(59);
        chk("scored_tick_ignored", 32'(play_en), 0);
        frames(1);
        chk("scored_pause_end", 32'(play_en), 1);

        // nine right exits win the game for player 1
        for (int g = 1; g <= 9; g++) begin
            ball_x = 10'd632;
            sb.push_back(EV_S1);
            if (g < 9) sb.push_back(EV_BR);
            frames(1);
            ball_x = 10'd320;
            if (g < 9) frames(60);
        end
        chk("win_game_over", 32'(game_over), 1);
        chk("win_winner", 32'(winner), 0);
        chk("win_play_en", 32'(play_en), 0);
        chk("win_p1_pts", 32'(dut.p1_pts), 9);
        b0 = br_cnt;
        for (int k = 0; k < 6; k++) begin
            start = ~start;
            frames(10);
        end
        chk("over_game_over", 32'(game_over), 1);
        chk("over_no_serve", 32'(br_cnt - b0), 0);
        chk("over_sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
